taxi_axis_pkt_gen: RTL and testbench

- AXI4-Stream frame transmitter: a source-only block that drives frames of configurable length onto a taxi_axis_if source port.
- Payload bytes are deterministic, so downstream checkers can predict every byte.
- Sits at the head of stream datapaths (registers, FIFOs, switches) as traffic source for bring-up and loopback test.
- Fully honours backpressure and never truncates a frame.

---
 rtl/taxi_axis_pkt_gen_if.sv | 36 +++
 rtl/taxi_axis_pkt_gen.sv | 248 ++++++++++++++++++++++++
 tb/tb_taxi_axis_pkt_gen.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/taxi_axis_pkt_gen_if.sv
// ---------------------------------------------------------------------------
// taxi_axis_if
//   AXI4-Stream bundle shared by the stream datapath blocks. Widths are
//   carried as interface parameters so the blocks attached to it can pick
//   them up without duplicating parameter lists.
//
//   Signals : tdata, tkeep, tstrb, tvalid, tready, tlast, tid, tdest, tuser
//   Modports: src (drives the stream), snk (consumes the stream)
// ---------------------------------------------------------------------------
interface taxi_axis_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 8,
  parameter int DEST_W = 8,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport src (
    output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport snk (
    input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/taxi_axis_pkt_gen.sv
// ---------------------------------------------------------------------------
// taxi_axis_pkt_gen
//   AXI4-Stream frame source for bring-up and loopback testing. After a
//   start pulse it emits cfg_count frames (or runs until stop when the count
//   is zero) of cfg_len bytes each. Byte k of every frame is
//   (cfg_seed + k) mod 256, so any downstream checker can predict the data.
//   Backpressure is fully honoured and frames are never truncated.
//
//   Ports:
//     clk          clock, rising edge
//     rst_n        asynchronous active-low reset
//     m_axis       AXI4-Stream source port
//     start        pulse: latch config and begin a run (ignored while busy)
//     stop         pulse: end the run at the next frame boundary
//     cfg_len      frame length in bytes (0 behaves as 1)
//     cfg_count    frames per run (0 = continuous until stop)
//     cfg_seed     first payload byte of every frame
//     cfg_id       tid used for the whole run
//     cfg_dest     tdest used for the whole run
//     busy         high while a run is in progress
//     frames_sent  frames completed since reset (wraps)
// ---------------------------------------------------------------------------
module taxi_axis_pkt_gen #(
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  taxi_axis_if.src          m_axis,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [7:0]        cfg_seed,
  input  logic [m_axis.ID_W-1:0]   cfg_id,
  input  logic [m_axis.DEST_W-1:0] cfg_dest,
  output logic              busy,
  output logic [STAT_W-1:0] frames_sent
);

  localparam int DATA_W = m_axis.DATA_W;
  localparam int KEEP_W = m_axis.KEEP_W;
  localparam int ID_W   = m_axis.ID_W;
  localparam int DEST_W = m_axis.DEST_W;
  localparam int USER_W = m_axis.USER_W;

  if ((DATA_W % 8) != 0 || KEEP_W != (DATA_W / 8)) begin : g_bad_width
    $fatal(1, "taxi_axis_pkt_gen: DATA_W must be a multiple of 8 and KEEP_W must equal DATA_W/8");
  end

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Lane i of a beat starting at byte offset off carries seed + off + i.
  // Only the low 8 bits of the offset matter because the pattern is mod 256.
  function automatic logic [DATA_W-1:0] beatData(input logic [7:0] seed,
                                                 input logic [LEN_W-1:0] off);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      d[i*8 +: 8] = seed + off[7:0] + 8'(i);
    end
    return d;
  endfunction

  // A lane is valid while it lies below the remaining byte count; on a
  // non-final beat the remainder exceeds KEEP_W so every lane is set.
  function automatic logic [KEEP_W-1:0] beatKeep(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] off);
    logic [KEEP_W-1:0] k;
    logic [LEN_W-1:0]  rem;
    rem = len - off;
    for (int i = 0; i < KEEP_W; i++) begin
      k[i] = (LEN_W'(i) < rem);
    end
    return k;
  endfunction

  function automatic logic beatLast(input logic [LEN_W-1:0] len,
                                    input logic [LEN_W-1:0] off);
    return ((len - off) <= LEN_W'(KEEP_W));
  endfunction

  state_t              r_state;
  logic [LEN_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_count;
  logic [7:0]          r_seed;
  logic [ID_W-1:0]     r_id;
  logic [DEST_W-1:0]   r_dest;
  logic [LEN_W-1:0]    r_offset;
  logic [CNT_W-1:0]    r_run_cnt;
  logic                r_stop_pending;
  logic [STAT_W-1:0]   r_frames_sent;
  logic                r_tvalid;
  logic [DATA_W-1:0]   r_tdata;
  logic [KEEP_W-1:0]   r_tkeep;
  logic                r_tlast;

  state_t              w_state;
  logic [LEN_W-1:0]    w_len;
  logic [CNT_W-1:0]    w_count;
  logic [7:0]          w_seed;
  logic [ID_W-1:0]     w_id;
  logic [DEST_W-1:0]   w_dest;
  logic [LEN_W-1:0]    w_offset;
  logic [CNT_W-1:0]    w_run_cnt;
  logic                w_stop_pending;
  logic [STAT_W-1:0]   w_frames_sent;
  logic                w_tvalid;
  logic [DATA_W-1:0]   w_tdata;
  logic [KEEP_W-1:0]   w_tkeep;
  logic                w_tlast;

  logic [LEN_W-1:0]    w_len_eff;
  logic [LEN_W-1:0]    w_next_off;
  logic [CNT_W-1:0]    w_run_cnt_inc;
  logic                w_xfer;
  logic                w_run_done;

  assign w_len_eff     = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign w_next_off    = r_offset + LEN_W'(KEEP_W);
  assign w_run_cnt_inc = r_run_cnt + CNT_W'(1);
  assign w_xfer        = r_tvalid && m_axis.tready;
  // A stop arriving alongside the tlast transfer still ends the run here.
  assign w_run_done    = ((r_count != '0) && (w_run_cnt_inc == r_count)) ||
                         r_stop_pending || stop;

  // Next-state and next-output logic. Output registers are loaded one beat
  // ahead so the stream runs at one beat per cycle with no bubbles, and
  // they are only reloaded on a transfer so payload stays stable under
  // backpressure.
  always_comb begin
    w_state        = r_state;
    w_len          = r_len;
    w_count        = r_count;
    w_seed         = r_seed;
    w_id           = r_id;
    w_dest         = r_dest;
    w_offset       = r_offset;
    w_run_cnt      = r_run_cnt;
    w_stop_pending = r_stop_pending;
    w_frames_sent  = r_frames_sent;
    w_tvalid       = r_tvalid;
    w_tdata        = r_tdata;
    w_tkeep        = r_tkeep;
    w_tlast        = r_tlast;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state        = ST_RUN;
          w_len          = w_len_eff;
          w_count        = cfg_count;
          w_seed         = cfg_seed;
          w_id           = cfg_id;
          w_dest         = cfg_dest;
          w_offset       = '0;
          w_run_cnt      = '0;
          w_stop_pending = 1'b0;
          w_tvalid       = 1'b1;
          w_tdata        = beatData(cfg_seed, '0);
          w_tkeep        = beatKeep(w_len_eff, '0);
          w_tlast        = beatLast(w_len_eff, '0);
        end
      end

      ST_RUN: begin
        if (stop) begin
          w_stop_pending = 1'b1;
        end
        if (w_xfer) begin
          if (r_tlast) begin
            w_frames_sent = r_frames_sent + STAT_W'(1);
            w_run_cnt     = w_run_cnt_inc;
            w_offset      = '0;
            if (w_run_done) begin
              w_state        = ST_IDLE;
              w_tvalid       = 1'b0;
              w_stop_pending = 1'b0;
            end else begin
              w_tdata = beatData(r_seed, '0);
              w_tkeep = beatKeep(r_len, '0);
              w_tlast = beatLast(r_len, '0);
            end
          end else begin
            w_offset = w_next_off;
            w_tdata  = beatData(r_seed, w_next_off);
            w_tkeep  = beatKeep(r_len, w_next_off);
            w_tlast  = beatLast(r_len, w_next_off);
          end
        end
      end

      default: begin
        w_state  = ST_IDLE;
        w_tvalid = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_len          <= '0;
      r_count        <= '0;
      r_seed         <= '0;
      r_id           <= '0;
      r_dest         <= '0;
      r_offset       <= '0;
      r_run_cnt      <= '0;
      r_stop_pending <= 1'b0;
      r_frames_sent  <= '0;
      r_tvalid       <= 1'b0;
      r_tdata        <= '0;
      r_tkeep        <= '0;
      r_tlast        <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_len          <= w_len;
      r_count        <= w_count;
      r_seed         <= w_seed;
      r_id           <= w_id;
      r_dest         <= w_dest;
      r_offset       <= w_offset;
      r_run_cnt      <= w_run_cnt;
      r_stop_pending <= w_stop_pending;
      r_frames_sent  <= w_frames_sent;
      r_tvalid       <= w_tvalid;
      r_tdata        <= w_tdata;
      r_tkeep        <= w_tkeep;
      r_tlast        <= w_tlast;
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tkeep  = r_tkeep;
  assign m_axis.tstrb  = r_tkeep;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tid    = r_id;
  assign m_axis.tdest  = r_dest;
  assign m_axis.tuser  = {USER_W{1'b0}};

  assign busy        = (r_state == ST_RUN);
  assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_taxi_axis_pkt_gen.sv
// ---------------------------------------------------------------------------
// tb_taxi_axis_pkt_gen
//   Self-checking bench for taxi_axis_pkt_gen. Each run's expected traffic
//   comes from a byte-queue model: a frame is the list of bytes
//   (seed + k) mod 256 for k < len, consumed KEEP_W bytes per beat.
// ---------------------------------------------------------------------------
module tb_taxi_axis_pkt_gen;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int ID_W   = 8;
  localparam int DEST_W = 8;
  localparam int USER_W = 1;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 16;
  localparam int STAT_W = 32;
  localparam int RUN_BOUND = 4000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [LEN_W-1:0]  cfg_len;
  logic [CNT_W-1:0]  cfg_count;
  logic [7:0]        cfg_seed;
  logic [ID_W-1:0]   cfg_id;
  logic [DEST_W-1:0] cfg_dest;
  logic              busy;
  logic [STAT_W-1:0] frames_sent;

  taxi_axis_if #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .ID_W(ID_W), .DEST_W(DEST_W), .USER_W(USER_W)
  ) axis ();

  taxi_axis_pkt_gen #(
    .LEN_W(LEN_W), .CNT_W(CNT_W), .STAT_W(STAT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_axis      (axis),
    .start       (start),
    .stop        (stop),
    .cfg_len     (cfg_len),
    .cfg_count   (cfg_count),
    .cfg_seed    (cfg_seed),
    .cfg_id      (cfg_id),
    .cfg_dest    (cfg_dest),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;
  logic [STAT_W-1:0] expFrames = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] laneMask(input logic [KEEP_W-1:0] keep);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_W; i++) m[i*8 +: 8] = keep[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // One run: launch, then watch every cycle until the model says the run is
  // over. readyMode 0 = always ready, 1 = alternating 1,0,..., 2 = random.
  // stopFrame < 0 means no stop pulse. restartMid pulses start mid-run.
  task automatic applyStimulus(input int len, input int count, input logic [7:0] seed,
                               input logic [7:0] id, input logic [7:0] dest,
                               input int readyMode, input int stopFrame,
                               input int stopBeat, input bit restartMid);
    byte unsigned      frameBytes[$];
    int                effLen;
    int                framesDone = 0;
    int                beatIdx = 0;
    int                cyc = 0;
    int                nb;
    bit                done = 0;
    bit                stopReq = 0;
    bit                stopSent = 0;
    bit                held = 0;
    logic [DATA_W-1:0] heldData, expData;
    logic [KEEP_W-1:0] heldKeep, expKeep;
    logic              heldLast, expLast;

    effLen = (len == 0) ? 1 : len;
    for (int k = 0; k < effLen; k++) frameBytes.push_back(8'(int'(seed) + k));

    @(negedge clk);
    cfg_len = LEN_W'(len); cfg_count = CNT_W'(count); cfg_seed = seed;
    cfg_id = id; cfg_dest = dest; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_len = LEN_W'($urandom); cfg_count = CNT_W'($urandom); cfg_seed = 8'($urandom);
    cfg_id = 8'($urandom); cfg_dest = 8'($urandom);
    checkOutput("start_latency_tvalid", 64'(axis.tvalid), 64'd1);
    checkOutput("start_busy", 64'(busy), 64'd1);

    while (!done && cyc < RUN_BOUND) begin
      case (readyMode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = ((cyc % 2) == 0);
        default: axis.tready = ($urandom_range(0, 99) < 60);
      endcase
      stop  = 1'b0;
      start = restartMid && (cyc == 3);
      if (!stopSent && stopFrame >= 0 && framesDone == stopFrame && beatIdx == stopBeat) begin
        stop = 1'b1; stopSent = 1; stopReq = 1;
      end

      if (held) begin
        checkOutput("hold_tdata", 64'(axis.tdata), 64'(heldData));
        checkOutput("hold_tkeep", 64'(axis.tkeep), 64'(heldKeep));
        checkOutput("hold_tlast", 64'(axis.tlast), 64'(heldLast));
      end
      checkOutput("run_tvalid", 64'(axis.tvalid), 64'd1);
      checkOutput("run_busy", 64'(busy), 64'd1);

      if (axis.tvalid && axis.tready) begin
        expData = '0; expKeep = '0; nb = 0;
        while (nb < KEEP_W && frameBytes.size() > 0) begin
          expData[nb*8 +: 8] = frameBytes.pop_front();
          expKeep[nb] = 1'b1;
          nb++;
        end
        expLast = (frameBytes.size() == 0);
        checkOutput("beat_tdata", 64'(axis.tdata & laneMask(expKeep)), 64'(expData));
        checkOutput("beat_tkeep", 64'(axis.tkeep), 64'(expKeep));
        checkOutput("beat_tstrb", 64'(axis.tstrb), 64'(expKeep));
        checkOutput("beat_tlast", 64'(axis.tlast), 64'(expLast));
        checkOutput("beat_tid", 64'(axis.tid), 64'(id));
        checkOutput("beat_tdest", 64'(axis.tdest), 64'(dest));
        checkOutput("beat_tuser", 64'(axis.tuser), 64'd0);
        held = 0;
        beatIdx++;
        if (expLast) begin
          framesDone++;
          expFrames++;
          beatIdx = 0;
          if ((count != 0 && framesDone == count) || stopReq) done = 1;
          else for (int k = 0; k < effLen; k++) frameBytes.push_back(8'(int'(seed) + k));
        end
      end else begin
        held = axis.tvalid;
        heldData = axis.tdata; heldKeep = axis.tkeep; heldLast = axis.tlast;
      end
      @(negedge clk);
      cyc++;
    end

    stop = 1'b0; start = 1'b0;
    checkOutput("run_completed_in_bound", 64'(done), 64'd1);
    checkOutput("end_tvalid", 64'(axis.tvalid), 64'd0);
    checkOutput("end_busy", 64'(busy), 64'd0);
    checkOutput("end_frames_sent", 64'(frames_sent), 64'(expFrames));
    repeat (3) @(negedge clk);
    checkOutput("idle_tvalid", 64'(axis.tvalid), 64'd0);
    axis.tready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; axis.tready = 1'b1;
    cfg_len = '0; cfg_count = '0; cfg_seed = '0; cfg_id = '0; cfg_dest = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_tvalid", 64'(axis.tvalid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_frames_sent", 64'(frames_sent), 64'd0);
    checkOutput("reset_tdata", 64'(axis.tdata), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_tvalid", 64'(axis.tvalid), 64'd0);

    $display("[TB] three-beat frame, len=20 seed=0x10");
    applyStimulus(20, 1, 8'h10, 8'h3A, 8'h5C, 0, -1, 0, 0);

    $display("[TB] stop while idle is ignored");
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    @(negedge clk);
    checkOutput("idle_stop_busy", 64'(busy), 64'd0);
    checkOutput("idle_stop_tvalid", 64'(axis.tvalid), 64'd0);

    $display("[TB] single-beat frames under alternating tready");
    applyStimulus(8, 3, 8'h00, 8'h01, 8'h02, 1, -1, 0, 0);

    $display("[TB] continuous run stopped mid frame");
    applyStimulus(64, 0, 8'h40, 8'h11, 8'h22, 0, 1, 3, 0);

    $display("[TB] zero length frame");
    applyStimulus(0, 1, 8'hFC, 8'h07, 8'h08, 0, -1, 0, 0);

    $display("[TB] seed wrap with start pulsed mid run");
    applyStimulus(8, 4, 8'hFC, 8'h09, 8'h0A, 1, -1, 0, 1);

    $display("[TB] stop on the final beat of a frame");
    applyStimulus(16, 0, 8'h80, 8'h33, 8'h44, 0, 2, 1, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      applyStimulus($urandom_range(0, 40), $urandom_range(1, 4), 8'($urandom),
                    8'($urandom), 8'($urandom), 2, -1, 0, 0);
    end

    $display("[TB] asynchronous reset mid frame");
    @(negedge clk);
    cfg_len = 16'd64; cfg_count = '0; cfg_seed = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0; axis.tready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_tvalid", 64'(axis.tvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_tvalid", 64'(axis.tvalid), 64'd0);
    checkOutput("async_reset_busy", 64'(busy), 64'd0);
    checkOutput("async_reset_frames_sent", 64'(frames_sent), 64'd0);
    checkOutput("async_reset_tlast", 64'(axis.tlast), 64'd0);
    expFrames = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    axis.tready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("after_reset_tvalid", 64'(axis.tvalid), 64'd0);
    checkOutput("after_reset_busy", 64'(busy), 64'd0);

    $display("[TB] run after reset");
    applyStimulus(12, 2, 8'hA0, 8'h0C, 8'h0D, 2, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
